// File: rtl/nonl_phimap_log_pipe.sv
// nonl_phimap_log_pipe
// Three-stage pipeline that expands a sample x into Mitchell-log words for
// x, sin(k*pi*x) and cos(k*pi*x), k = 1..H, each with a sign and a valid flag.
// Stage 1 forms the quarter-wave table index for every harmonic, stage 2 reads
// the sine table and resolves the quadrant, and stage 3 converts every
// magnitude to the log domain straight into the output registers.
// The sine table holds 65 entries for 64 steps per quadrant. A smaller
// LUT_WIDTH reads it with a stride; LUT_WIDTH above 7 is not supported.
// Magnitudes are handled as 16-bit words, so WIDTH is expected to be 16 or less.

module nonl_phimap_log_pipe #(
  parameter int Q_ORD     = 7,
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LUT_WIDTH = 7,
  parameter int LOG_WIDTH = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [WIDTH-1:0]      x_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [Q_ORD*LOG_WIDTH-1:0]   nonl_x_out_packed,
  output logic [Q_ORD-1:0]             nonl_x_out_sign_packed,
  output logic [Q_ORD-1:0]             nonl_x_out_valid_packed,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int H         = (Q_ORD - 1) / 2;
  localparam int N         = 1 << (LUT_WIDTH - 1);
  localparam int TW        = LUT_WIDTH + 3;
  localparam int IDX_LSB   = QP - LUT_WIDTH;
  localparam int LUT_SHIFT = (LUT_WIDTH < 7) ? (7 - LUT_WIDTH) : 0;
  localparam logic [WIDTH-1:0] RND = WIDTH'(1) << (QP - LUT_WIDTH - 1);

  // Quarter-wave sine table, S(j) = round(32768*sin(pi*j/128)) capped at 32767.
  function automatic logic [15:0] sine_lut(input logic [LUT_WIDTH-1:0] j);
    logic [6:0] a;
    a = 7'(j) << LUT_SHIFT;
    case (a)
      7'd0:  sine_lut = 16'd0;     7'd1:  sine_lut = 16'd804;   7'd2:  sine_lut = 16'd1608;
      7'd3:  sine_lut = 16'd2411;  7'd4:  sine_lut = 16'd3212;  7'd5:  sine_lut = 16'd4011;
      7'd6:  sine_lut = 16'd4808;  7'd7:  sine_lut = 16'd5602;  7'd8:  sine_lut = 16'd6393;
      7'd9:  sine_lut = 16'd7180;  7'd10: sine_lut = 16'd7962;  7'd11: sine_lut = 16'd8740;
      7'd12: sine_lut = 16'd9512;  7'd13: sine_lut = 16'd10279; 7'd14: sine_lut = 16'd11039;
      7'd15: sine_lut = 16'd11793; 7'd16: sine_lut = 16'd12540; 7'd17: sine_lut = 16'd13279;
      7'd18: sine_lut = 16'd14010; 7'd19: sine_lut = 16'd14733; 7'd20: sine_lut = 16'd15447;
      7'd21: sine_lut = 16'd16151; 7'd22: sine_lut = 16'd16846; 7'd23: sine_lut = 16'd17531;
      7'd24: sine_lut = 16'd18205; 7'd25: sine_lut = 16'd18868; 7'd26: sine_lut = 16'd19520;
      7'd27: sine_lut = 16'd20160; 7'd28: sine_lut = 16'd20788; 7'd29: sine_lut = 16'd21403;
      7'd30: sine_lut = 16'd22006; 7'd31: sine_lut = 16'd22595; 7'd32: sine_lut = 16'd23170;
      7'd33: sine_lut = 16'd23732; 7'd34: sine_lut = 16'd24279; 7'd35: sine_lut = 16'd24812;
      7'd36: sine_lut = 16'd25330; 7'd37: sine_lut = 16'd25833; 7'd38: sine_lut = 16'd26320;
      7'd39: sine_lut = 16'd26791; 7'd40: sine_lut = 16'd27246; 7'd41: sine_lut = 16'd27684;
      7'd42: sine_lut = 16'd28106; 7'd43: sine_lut = 16'd28511; 7'd44: sine_lut = 16'd28899;
      7'd45: sine_lut = 16'd29269; 7'd46: sine_lut = 16'd29622; 7'd47: sine_lut = 16'd29957;
      7'd48: sine_lut = 16'd30274; 7'd49: sine_lut = 16'd30572; 7'd50: sine_lut = 16'd30853;
      7'd51: sine_lut = 16'd31114; 7'd52: sine_lut = 16'd31357; 7'd53: sine_lut = 16'd31581;
      7'd54: sine_lut = 16'd31786; 7'd55: sine_lut = 16'd31972; 7'd56: sine_lut = 16'd32138;
      7'd57: sine_lut = 16'd32286; 7'd58: sine_lut = 16'd32413; 7'd59: sine_lut = 16'd32522;
      7'd60: sine_lut = 16'd32610; 7'd61: sine_lut = 16'd32679; 7'd62: sine_lut = 16'd32729;
      7'd63: sine_lut = 16'd32758; 7'd64: sine_lut = 16'd32767;
      default: sine_lut = 16'd0;
    endcase
  endfunction

  // Quadrant resolution; result layout is {sin_neg, sin_mag, cos_neg, cos_mag}.
  function automatic logic [33:0] trig_terms(input logic [LUT_WIDTH:0] tk);
    logic [1:0]           q;
    logic [LUT_WIDTH-1:0] m;
    logic [LUT_WIDTH-1:0] nm;
    logic [15:0]          s_m;
    logic [15:0]          s_nm;
    q    = tk[LUT_WIDTH -: 2];
    m    = {1'b0, tk[LUT_WIDTH-2:0]};
    nm   = LUT_WIDTH'(N) - m;
    s_m  = sine_lut(m);
    s_nm = sine_lut(nm);
    case (q)
      2'd0:    trig_terms = {1'b0, s_m,  1'b0, s_nm};
      2'd1:    trig_terms = {1'b0, s_nm, 1'b1, s_m};
      2'd2:    trig_terms = {1'b1, s_m,  1'b1, s_nm};
      default: trig_terms = {1'b1, s_nm, 1'b0, s_m};
    endcase
  endfunction

  // Mitchell log: signed exponent (MSB position minus off) above 12 truncated
  // mantissa bits, sign-extended to LOG_WIDTH; a zero magnitude yields word 0.
  function automatic logic [LOG_WIDTH-1:0] mitchell(input logic [15:0] mag, input int off);
    logic [3:0]  p;
    logic [15:0] norm;
    logic [4:0]  expo;
    logic [11:0] frac;
    logic signed [LOG_WIDTH-1:0] word;
    p = '0;
    for (int b = 0; b < 16; b++) begin
      if (mag[b]) p = 4'(b);
    end
    norm = mag << (4'd15 - p);
    frac = 12'(norm >> 3);
    expo = {1'b0, p} - 5'(off);
    word = LOG_WIDTH'($signed({expo, frac}));
    if (mag == '0) word = '0;
    return word;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 index: round x to the table grid and keep the angle bits.
  logic [WIDTH-1:0] r_sum;
  logic [TW-1:0]    t_idx;
  logic             unused_r;
  assign r_sum    = $unsigned(x_in) + RND;
  assign t_idx    = r_sum[IDX_LSB +: TW];
  assign unused_r = ^r_sum;

  logic [TW-1:0]           tk_s1 [H];
  logic signed [WIDTH-1:0] x_s1;
  logic                    v_s1;

  // Stage 1 registers: harmonic indices k*t, the raw sample and its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_s1 <= 1'b0;
      x_s1 <= '0;
      for (int i = 0; i < H; i++) tk_s1[i] <= '0;
    end else if (adv) begin
      v_s1 <= in_valid;
      x_s1 <= x_in;
      for (int i = 0; i < H; i++) tk_s1[i] <= t_idx * TW'(i + 1);
    end
  end

  // Only the quadrant and step bits of each harmonic index matter downstream.
  logic unused_tk;
  always_comb begin
    unused_tk = 1'b0;
    for (int i = 0; i < H; i++) unused_tk = unused_tk ^ (^tk_s1[i]);
  end

  logic [WIDTH-1:0] xmag_w;
  assign xmag_w = x_s1[WIDTH-1] ? (~$unsigned(x_s1) + WIDTH'(1)) : $unsigned(x_s1);

  logic [33:0] trig_s2 [H];
  logic [15:0] xmag_s2;
  logic        xneg_s2;
  logic        v_s2;

  // Stage 2 registers: signed sine/cosine magnitudes per harmonic and |x|.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_s2    <= 1'b0;
      xmag_s2 <= '0;
      xneg_s2 <= 1'b0;
      for (int i = 0; i < H; i++) trig_s2[i] <= '0;
    end else if (adv) begin
      v_s2    <= v_s1;
      xmag_s2 <= 16'(xmag_w);
      xneg_s2 <= x_s1[WIDTH-1];
      for (int i = 0; i < H; i++) trig_s2[i] <= trig_terms(tk_s1[i][LUT_WIDTH:0]);
    end
  end

  logic [Q_ORD*LOG_WIDTH-1:0] word_nx;
  logic [Q_ORD-1:0]           sign_nx;
  logic [Q_ORD-1:0]           valid_nx;

  // Stage 3 log conversion; term 0 is x, then sin/cos pairs per harmonic.
  always_comb begin
    word_nx  = '0;
    sign_nx  = '0;
    valid_nx = '0;
    word_nx[0 +: LOG_WIDTH] = mitchell(xmag_s2, QP);
    valid_nx[0] = (xmag_s2 != '0);
    sign_nx[0]  = xneg_s2 && (xmag_s2 != '0);
    for (int k = 0; k < H; k++) begin
      word_nx[(2*k+1)*LOG_WIDTH +: LOG_WIDTH] = mitchell(trig_s2[k][32:17], 15);
      valid_nx[2*k+1] = (trig_s2[k][32:17] != '0);
      sign_nx[2*k+1]  = trig_s2[k][33] && (trig_s2[k][32:17] != '0);
      word_nx[(2*k+2)*LOG_WIDTH +: LOG_WIDTH] = mitchell(trig_s2[k][15:0], 15);
      valid_nx[2*k+2] = (trig_s2[k][15:0] != '0);
      sign_nx[2*k+2]  = trig_s2[k][16] && (trig_s2[k][15:0] != '0);
    end
  end

  // Output registers; they hold while the downstream stage stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid               <= 1'b0;
      nonl_x_out_packed       <= '0;
      nonl_x_out_sign_packed  <= '0;
      nonl_x_out_valid_packed <= '0;
    end else if (adv) begin
      out_valid               <= v_s2;
      nonl_x_out_packed       <= word_nx;
      nonl_x_out_sign_packed  <= sign_nx;
      nonl_x_out_valid_packed <= valid_nx;
    end
  end

endmodule

// File: tb/tb_nonl_phimap_log_pipe.sv
// tb_nonl_phimap_log_pipe
// Directed bench: a table of samples with hand-derived log words, then a
// stalled stream, a mid-stream reset, and a nine-term instance check.

module tb_nonl_phimap_log_pipe;

  localparam int LW = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [15:0] x_in;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7*LW-1:0]   word7;
  logic [6:0]        sign7;
  logic [6:0]        valid7;
  logic              in_ready9;
  logic              out_valid9;
  logic [9*LW-1:0]   word9;
  logic [8:0]        sign9;
  logic [8:0]        valid9;

  typedef struct packed {
    logic [15:0]         x;
    logic [6:0][LW-1:0]  words;
    logic [6:0]          sign;
    logic [6:0]          valid;
  } vec_t;

  vec_t vecs [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  nonl_phimap_log_pipe dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .nonl_x_out_packed(word7), .nonl_x_out_sign_packed(sign7),
    .nonl_x_out_valid_packed(valid7), .out_valid(out_valid), .out_ready(out_ready)
  );

  nonl_phimap_log_pipe #(.Q_ORD(9)) dut9 (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready9),
    .nonl_x_out_packed(word9), .nonl_x_out_sign_packed(sign9),
    .nonl_x_out_valid_packed(valid9), .out_valid(out_valid9), .out_ready(out_ready)
  );

  function automatic vec_t mk(input logic [15:0] x,
                              input logic [LW-1:0] w0, w1, w2, w3, w4, w5, w6,
                              input logic [6:0] s, input logic [6:0] v);
    vec_t r;
    r.x     = x;
    r.words = {w6, w5, w4, w3, w2, w1, w0};
    r.sign  = s;
    r.valid = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBundle(input string tag, input vec_t v);
    checkOutput({tag, "_valid_out"}, out_valid, 1);
    checkOutput({tag, "_words"}, word7, v.words);
    checkOutput({tag, "_sign"}, sign7, v.sign);
    checkOutput({tag, "_valid_flags"}, valid7, v.valid);
  endtask

  // One sample in, then count edges until out_valid (bounded).
  task automatic applyStimulus(input logic [15:0] x, output int lat);
    @(negedge clk);
    x_in     = x;
    in_valid = 1'b1;
    #1;
    checkOutput("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int q_idx[$];
    int ptr;
    int got;
    int stall;
    int idx;
    logic was_stall;
    logic [7*LW-1:0] held_w;
    logic [6:0] held_s;
    logic [6:0] held_v;

    // S(64) = 32767 -> 0x1FFFF; S(32) = 23170 -> p = 14, frac 0x6A0 -> 0x1F6A0.
    vecs[0] = mk(16'h0800, 17'h1F000, 17'h1FFFF, 17'h0, 17'h0, 17'h1FFFF, 17'h1FFFF, 17'h0, 7'h30, 7'h33);
    vecs[1] = mk(16'h0000, 17'h0, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 7'h00, 7'h54);
    vecs[2] = mk(16'h8000, 17'h03000, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 7'h01, 7'h55);
    vecs[3] = mk(16'h0400, 17'h1E000, 17'h1F6A0, 17'h1F6A0, 17'h1FFFF, 17'h0, 17'h1F6A0, 17'h1F6A0, 7'h40, 7'h6F);
    vecs[4] = mk(16'hF800, 17'h1F000, 17'h1FFFF, 17'h0, 17'h0, 17'h1FFFF, 17'h1FFFF, 17'h0, 7'h13, 7'h33);
    vecs[5] = mk(16'h0C00, 17'h1F800, 17'h1F6A0, 17'h1F6A0, 17'h1FFFF, 17'h0, 17'h1F6A0, 17'h1F6A0, 7'h0C, 7'h6F);
    vecs[6] = mk(16'h7FFF, 17'h02FFF, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 7'h00, 7'h55);
    vecs[7] = mk(16'hFFFF, 17'h14000, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 17'h0, 17'h1FFFF, 7'h01, 7'h55);

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_words", word7, 0);
    checkOutput("reset_sign", sign7, 0);
    checkOutput("reset_valid_flags", valid7, 0);
    reset = 1'b0;

    // Table-driven single samples, latency and contents.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].x, lat);
      checkOutput($sformatf("latency_v%0d", i), lat, 3);
      checkBundle($sformatf("vec%0d", i), vecs[i]);
      if (i == 3) begin
        checkOutput("q9_out_valid", out_valid9, 1);
        checkOutput("q9_words", word9, {17'h1FFFF, 17'h0, vecs[3].words});
        checkOutput("q9_sign", sign9, 9'h140);
        checkOutput("q9_valid_flags", valid9, 9'h16F);
      end
    end

    // Stream of five samples with out_ready low for cycles 4..6.
    @(negedge clk);
    ptr = 0;
    got = 0;
    stall = 0;
    was_stall = 1'b0;
    held_w = '0;
    held_s = '0;
    held_v = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (ptr < 5);
      if (ptr < 5) x_in = vecs[ptr].x;
      #1;
      if (was_stall) begin
        checkOutput("stall_hold_words", word7, held_w);
        checkOutput("stall_hold_sign", sign7, held_s);
        checkOutput("stall_hold_valid_flags", valid7, held_v);
      end
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 0);
        stall++;
        held_w = word7;
        held_s = sign7;
        held_v = valid7;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q_idx.size() == 0) begin
          checkOutput("stream_spurious_output", q_idx.size(), 1);
        end else begin
          idx = q_idx.pop_front();
          checkBundle($sformatf("stream%0d", got), vecs[idx]);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q_idx.push_back(ptr);
        ptr++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", got, 5);
    checkOutput("stream_stall_cycles", stall, 3);
    checkOutput("stream_no_extra", out_valid, 0);

    // Reset with two samples in flight; a sample offered during reset is ignored.
    @(negedge clk);
    x_in = 16'h0800;
    in_valid = 1'b1;
    @(negedge clk);
    x_in = 16'h0400;
    @(negedge clk);
    x_in  = 16'h7FFF;
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_words", word7, 0);
    checkOutput("midreset_valid_flags", valid7, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midreset_flushed_c%0d", i), out_valid, 0);
    end
    applyStimulus(vecs[5].x, lat);
    checkOutput("midreset_latency", lat, 3);
    checkBundle("after_reset", vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
